atm: RTL and testbench

- Single-card ATM controller FSM with an internal 4-entry account database holding account number, PIN and balance.
- Sequences card insertion, language select, PIN check, menu, transaction, receipt, another-transaction and exit.
- Supports balance, withdraw, deposit, transfer and PIN change; reports each outcome as a one-cycle success pulse.
- Top-level block of the ATM banking subsystem.

---
 rtl/atm_pkg.sv | 61 ++++++
 rtl/atm_account_db.sv | 75 +++++++
 rtl/atm.sv | 240 ++++++++++++++++++++++++
 tb/tb_atm.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM controller: FSM states, menu opcodes,
// field widths and the power-on contents of the account database.
package atm_pkg;

  localparam int NUM_ACCOUNTS = 4;
  localparam int ACCT_W       = 17;
  localparam int PIN_W        = 17;
  localparam int AMT_W        = 19;
  localparam int IDX_W        = $clog2(NUM_ACCOUNTS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LANG,
    S_PIN,
    S_MENU,
    S_BALANCE,
    S_WITHDRAW,
    S_DEPOSIT,
    S_TRANSFER,
    S_CHANGE_PIN,
    S_RECEIPT,
    S_ANOTHER,
    S_EXIT
  } state_e;

  localparam logic [2:0] OP_BALANCE    = 3'b001;
  localparam logic [2:0] OP_WITHDRAW   = 3'b010;
  localparam logic [2:0] OP_DEPOSIT    = 3'b011;
  localparam logic [2:0] OP_TRANSFER   = 3'b100;
  localparam logic [2:0] OP_CHANGE_PIN = 3'b101;

  function automatic logic [ACCT_W-1:0] init_acct(input int i);
    case (i)
      0:       return ACCT_W'(1000);
      1:       return ACCT_W'(2000);
      2:       return ACCT_W'(3000);
      3:       return ACCT_W'(4000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [PIN_W-1:0] init_pin(input int i);
    case (i)
      0:       return PIN_W'(1111);
      1:       return PIN_W'(2222);
      2:       return PIN_W'(3333);
      3:       return PIN_W'(4444);
      default: return '0;
    endcase
  endfunction

  function automatic logic [AMT_W-1:0] init_bal(input int i);
    case (i)
      0:       return AMT_W'(5000);
      1:       return AMT_W'(3000);
      2:       return AMT_W'(1000);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/atm_account_db.sv
// Account register file: two account-number lookups, two balance read ports,
// two balance write ports (so a transfer commits both sides on one edge) and a PIN write port.
module atm_account_db
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ACCT_W-1:0] i_lka_acct,
  output logic              o_lka_hit,
  output logic [IDX_W-1:0]  o_lka_idx,
  input  logic [ACCT_W-1:0] i_lkb_acct,
  output logic              o_lkb_hit,
  output logic [IDX_W-1:0]  o_lkb_idx,
  input  logic [IDX_W-1:0]  i_rda_idx,
  output logic [PIN_W-1:0]  o_rda_pin,
  output logic [AMT_W-1:0]  o_rda_bal,
  input  logic [IDX_W-1:0]  i_rdb_idx,
  output logic [AMT_W-1:0]  o_rdb_bal,
  input  logic              i_wra_en,
  input  logic [IDX_W-1:0]  i_wra_idx,
  input  logic [AMT_W-1:0]  i_wra_bal,
  input  logic              i_wrb_en,
  input  logic [IDX_W-1:0]  i_wrb_idx,
  input  logic [AMT_W-1:0]  i_wrb_bal,
  input  logic              i_pin_we,
  input  logic [IDX_W-1:0]  i_pin_idx,
  input  logic [PIN_W-1:0]  i_pin_data
);

  logic [ACCT_W-1:0] r_acct [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  r_pin  [NUM_ACCOUNTS];
  logic [AMT_W-1:0]  r_bal  [NUM_ACCOUNTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_acct[i] <= init_acct(i);
        r_pin[i]  <= init_pin(i);
        r_bal[i]  <= init_bal(i);
      end
    end else begin
      if (i_wra_en) r_bal[i_wra_idx] <= i_wra_bal;
      if (i_wrb_en) r_bal[i_wrb_idx] <= i_wrb_bal;
      if (i_pin_we) r_pin[i_pin_idx] <= i_pin_data;
    end
  end

  // Downward scan so the lowest matching index wins if numbers ever collide.
  always_comb begin
    o_lka_hit = 1'b0;
    o_lka_idx = '0;
    for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
      if (r_acct[i] == i_lka_acct) begin
        o_lka_hit = 1'b1;
        o_lka_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    o_lkb_hit = 1'b0;
    o_lkb_idx = '0;
    for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
      if (r_acct[i] == i_lkb_acct) begin
        o_lkb_hit = 1'b1;
        o_lkb_idx = IDX_W'(i);
      end
    end
  end

  assign o_rda_pin = r_pin[i_rda_idx];
  assign o_rda_bal = r_bal[i_rda_idx];
  assign o_rdb_bal = r_bal[i_rdb_idx];

endmodule

// File: rtl/atm.sv
// Single-card ATM controller FSM over a small account database.
// Optional PIN_LOCKOUT_EN: exhausting PIN tries locks that account until reset.
module atm
  import atm_pkg::*;
#(
  parameter int MAX_PIN_TRIES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Card_in,
  input  logic              Language,
  input  logic              Timer,
  input  logic              money_counting,
  input  logic              another_transaction_bit,
  input  logic [2:0]        opcode,
  input  logic [PIN_W-1:0]  password,
  input  logic [PIN_W-1:0]  new_pin,
  input  logic              allowwithdraw,
  input  logic              take_receipt,
  input  logic              allow_transfer,
  input  logic [ACCT_W-1:0] Pers_Account_No,
  input  logic [ACCT_W-1:0] ur_account,
  input  logic [AMT_W-1:0]  withdraw_amount,
  input  logic [AMT_W-1:0]  Transfer_Amount,
  input  logic [AMT_W-1:0]  deposit_amount,
  output logic              Transfer_Successfully,
  output logic              ATM_Usage_Finished,
  output logic              Balance_Shown,
  output logic              Deposited_Successfully,
  output logic              Withdrew_Successfully,
  output logic              Pin_Changed_Successfully,
  output logic              Receipt_Printed
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

  // True when a + b stays within the unsigned amount range (no wrap).
  function automatic logic fits_add(input logic [AMT_W-1:0] a, input logic [AMT_W-1:0] b);
    logic [AMT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return !s[AMT_W];
  endfunction

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TRY_W-1:0]   r_tries;
  logic               r_lang;

  logic               w_card_hit;
  logic [IDX_W-1:0]   w_card_idx;
  logic               w_dst_hit;
  logic [IDX_W-1:0]   w_dst_idx;
  logic [PIN_W-1:0]   w_own_pin;
  logic [AMT_W-1:0]   w_own_bal;
  logic [AMT_W-1:0]   w_dst_bal;
  logic               w_abort;
  logic               w_pin_ok;
  logic               w_pin_last;
  logic               w_locked;
  logic               w_wd_ok;
  logic               w_dep_ok;
  logic               w_xfer_ok;
  logic               w_wra_en;
  logic [AMT_W-1:0]   w_wra_bal;
  logic               w_wrb_en;
  logic [AMT_W-1:0]   w_wrb_bal;
  logic               w_pin_we;

  atm_account_db u_db (
    .clk        (clk),
    .reset      (reset),
    .i_lka_acct (Pers_Account_No),
    .o_lka_hit  (w_card_hit),
    .o_lka_idx  (w_card_idx),
    .i_lkb_acct (ur_account),
    .o_lkb_hit  (w_dst_hit),
    .o_lkb_idx  (w_dst_idx),
    .i_rda_idx  (r_idx),
    .o_rda_pin  (w_own_pin),
    .o_rda_bal  (w_own_bal),
    .i_rdb_idx  (w_dst_idx),
    .o_rdb_bal  (w_dst_bal),
    .i_wra_en   (w_wra_en),
    .i_wra_idx  (r_idx),
    .i_wra_bal  (w_wra_bal),
    .i_wrb_en   (w_wrb_en),
    .i_wrb_idx  (w_dst_idx),
    .i_wrb_bal  (w_wrb_bal),
    .i_pin_we   (w_pin_we),
    .i_pin_idx  (r_idx),
    .i_pin_data (new_pin)
  );

  assign w_abort    = (r_state != S_IDLE) && (r_state != S_EXIT) && (!Card_in || Timer);
  assign w_pin_ok   = (password == w_own_pin);
  assign w_pin_last = (r_tries == TRY_W'(MAX_PIN_TRIES - 1));

  assign w_wd_ok   = allowwithdraw && (withdraw_amount != '0) && (withdraw_amount <= w_own_bal);
  assign w_dep_ok  = money_counting && (deposit_amount != '0) && fits_add(w_own_bal, deposit_amount);
  assign w_xfer_ok = allow_transfer && w_dst_hit && (w_dst_idx != r_idx) &&
                     (Transfer_Amount != '0) && (Transfer_Amount <= w_own_bal) &&
                     fits_add(w_dst_bal, Transfer_Amount);
  assign w_wrb_bal = w_dst_bal + Transfer_Amount;

  // Database writes; an abort cycle commits nothing.
  always_comb begin
    w_wra_en  = 1'b0;
    w_wra_bal = w_own_bal;
    w_wrb_en  = 1'b0;
    w_pin_we  = 1'b0;
    if (!w_abort) begin
      case (r_state)
        S_WITHDRAW: begin
          w_wra_en  = w_wd_ok;
          w_wra_bal = w_own_bal - withdraw_amount;
        end
        S_DEPOSIT: begin
          w_wra_en  = w_dep_ok;
          w_wra_bal = w_own_bal + deposit_amount;
        end
        S_TRANSFER: begin
          w_wra_en  = w_xfer_ok;
          w_wra_bal = w_own_bal - Transfer_Amount;
          w_wrb_en  = w_xfer_ok;
        end
        S_CHANGE_PIN: w_pin_we = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIN_LOCKOUT_EN
  logic [NUM_ACCOUNTS-1:0] r_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= '0;
    end else if ((r_state == S_PIN) && !w_abort && !w_pin_ok && w_pin_last) begin
      r_lock[r_idx] <= 1'b1;
    end
  end

  assign w_locked = r_lock[w_card_idx];
`else
  assign w_locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                  <= S_IDLE;
      r_idx                    <= '0;
      r_tries                  <= '0;
      r_lang                   <= 1'b0;
      Transfer_Successfully    <= 1'b0;
      ATM_Usage_Finished       <= 1'b0;
      Balance_Shown            <= 1'b0;
      Deposited_Successfully   <= 1'b0;
      Withdrew_Successfully    <= 1'b0;
      Pin_Changed_Successfully <= 1'b0;
      Receipt_Printed          <= 1'b0;
    end else begin
      Transfer_Successfully    <= 1'b0;
      ATM_Usage_Finished       <= 1'b0;
      Balance_Shown            <= 1'b0;
      Deposited_Successfully   <= 1'b0;
      Withdrew_Successfully    <= 1'b0;
      Pin_Changed_Successfully <= 1'b0;
      Receipt_Printed          <= 1'b0;
      if (w_abort) begin
        r_state <= S_EXIT;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Card_in && w_card_hit && !w_locked) begin
              r_idx   <= w_card_idx;
              r_state <= S_LANG;
            end
          end
          S_LANG: begin
            r_lang  <= Language;
            r_state <= S_PIN;
          end
          S_PIN: begin
            if (w_pin_ok) begin
              r_tries <= '0;
              r_state <= S_MENU;
            end else begin
              r_tries <= r_tries + 1'b1;
              if (w_pin_last) r_state <= S_EXIT;
            end
          end
          S_MENU: begin
            case (opcode)
              OP_BALANCE:    r_state <= S_BALANCE;
              OP_WITHDRAW:   r_state <= S_WITHDRAW;
              OP_DEPOSIT:    r_state <= S_DEPOSIT;
              OP_TRANSFER:   r_state <= S_TRANSFER;
              OP_CHANGE_PIN: r_state <= S_CHANGE_PIN;
              default:       r_state <= S_EXIT;
            endcase
          end
          S_BALANCE: begin
            Balance_Shown <= 1'b1;
            r_state       <= S_RECEIPT;
          end
          S_WITHDRAW: begin
            Withdrew_Successfully <= w_wd_ok;
            r_state               <= S_RECEIPT;
          end
          S_DEPOSIT: begin
            if (money_counting) begin
              Deposited_Successfully <= w_dep_ok;
              r_state                <= S_RECEIPT;
            end
          end
          S_TRANSFER: begin
            Transfer_Successfully <= w_xfer_ok;
            r_state               <= S_RECEIPT;
          end
          S_CHANGE_PIN: begin
            Pin_Changed_Successfully <= 1'b1;
            r_state                  <= S_RECEIPT;
          end
          S_RECEIPT: begin
            Receipt_Printed <= take_receipt;
            r_state         <= S_ANOTHER;
          end
          S_ANOTHER: r_state <= another_transaction_bit ? S_MENU : S_EXIT;
          S_EXIT: begin
            ATM_Usage_Finished <= 1'b1;
            r_tries            <= '0;
            r_state            <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm.sv
// Bench for the ATM controller: directed scenarios plus randomized sessions
// scored against a plain account/balance model kept in the bench.
module tb_atm;

  logic        clk = 1'b0;
  logic        reset;
  logic        Card_in, Language, Timer, money_counting, another_transaction_bit;
  logic [2:0]  opcode;
  logic [16:0] password, new_pin, Pers_Account_No, ur_account;
  logic        allowwithdraw, take_receipt, allow_transfer;
  logic [18:0] withdraw_amount, Transfer_Amount, deposit_amount;
  logic        Transfer_Successfully, ATM_Usage_Finished, Balance_Shown;
  logic        Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully;
  logic        Receipt_Printed;

  atm dut (
    .clk(clk), .reset(reset), .Card_in(Card_in), .Language(Language), .Timer(Timer),
    .money_counting(money_counting), .another_transaction_bit(another_transaction_bit),
    .opcode(opcode), .password(password), .new_pin(new_pin), .allowwithdraw(allowwithdraw),
    .take_receipt(take_receipt), .allow_transfer(allow_transfer),
    .Pers_Account_No(Pers_Account_No), .ur_account(ur_account),
    .withdraw_amount(withdraw_amount), .Transfer_Amount(Transfer_Amount),
    .deposit_amount(deposit_amount), .Transfer_Successfully(Transfer_Successfully),
    .ATM_Usage_Finished(ATM_Usage_Finished), .Balance_Shown(Balance_Shown),
    .Deposited_Successfully(Deposited_Successfully), .Withdrew_Successfully(Withdrew_Successfully),
    .Pin_Changed_Successfully(Pin_Changed_Successfully), .Receipt_Printed(Receipt_Printed)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] P_XFER = 7'b1000000;
  localparam logic [6:0] P_FIN  = 7'b0100000;
  localparam logic [6:0] P_BAL  = 7'b0010000;
  localparam logic [6:0] P_DEP  = 7'b0001000;
  localparam logic [6:0] P_WD   = 7'b0000100;
  localparam logic [6:0] P_PINC = 7'b0000010;
  localparam logic [6:0] P_RCPT = 7'b0000001;
  localparam int AMT_LIMIT = 524287;

  int n_checks = 0;
  int n_fail   = 0;
  int m_acct [4];
  int m_pin  [4];
  int m_bal  [4];
  logic [6:0] w_outs;
  logic [6:0] obs;
  logic [6:0] sess_or;
  logic [6:0] trace [$];

  assign w_outs = {Transfer_Successfully, ATM_Usage_Finished, Balance_Shown, Deposited_Successfully,
                   Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed};

  task automatic tick();
    @(posedge clk);
    #1;
    obs = w_outs;
    sess_or |= obs;
    trace.push_back(obs);
  endtask

  task automatic idle_inputs();
    Card_in = 0; Language = 0; Timer = 0; money_counting = 0; another_transaction_bit = 0;
    opcode = 0; password = 0; new_pin = 0; allowwithdraw = 0; take_receipt = 0;
    allow_transfer = 0; Pers_Account_No = 0; ur_account = 0;
    withdraw_amount = 0; Transfer_Amount = 0; deposit_amount = 0;
  endtask

  task automatic model_reset();
    m_acct = '{1000, 2000, 3000, 4000};
    m_pin  = '{1111, 2222, 3333, 4444};
    m_bal  = '{5000, 3000, 1000, 0};
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic begin_trace();
    sess_or = 0;
    trace.delete();
  endtask

  function automatic int find_acct(input int acct);
    for (int i = 0; i < 4; i++) if (m_acct[i] == acct) return i;
    return -1;
  endfunction

  // Model of one full session with the correct PIN; returns the pulses it should produce.
  function automatic logic [6:0] model_session(input int acct, input int op, input int amt,
                                               input int dest, input bit confirm,
                                               input bit receipt, input int npin);
    int a, d;
    logic [6:0] m;
    a = find_acct(acct);
    m = P_FIN | (receipt ? P_RCPT : 7'b0);
    case (op)
      1: m |= P_BAL;
      2: if (confirm && amt > 0 && amt <= m_bal[a]) begin m_bal[a] -= amt; m |= P_WD; end
      3: if (amt > 0 && m_bal[a] + amt <= AMT_LIMIT) begin m_bal[a] += amt; m |= P_DEP; end
      4: begin
        d = find_acct(dest);
        if (confirm && d >= 0 && d != a && amt > 0 && amt <= m_bal[a] && m_bal[d] + amt <= AMT_LIMIT) begin
          m_bal[a] -= amt; m_bal[d] += amt; m |= P_XFER;
        end
      end
      5: begin m_pin[a] = npin; m |= P_PINC; end
      default: ;
    endcase
    return m;
  endfunction

  // Drives card-in through exit; trace[4] is the transaction outcome when dep_wait is 0.
  task automatic run_session(input int acct, input int pin, input int op, input int amt,
                             input int dest, input bit confirm, input bit receipt,
                             input int dep_wait, input int npin);
    begin_trace();
    Card_in = 1; Pers_Account_No = 17'(acct); password = 17'(pin); Language = 1'($urandom);
    tick(); tick(); tick();
    opcode = 3'(op);
    tick();
    withdraw_amount = 19'(amt); deposit_amount = 19'(amt); Transfer_Amount = 19'(amt);
    ur_account = 17'(dest); allowwithdraw = confirm; allow_transfer = confirm; new_pin = 17'(npin);
    money_counting = 0;
    repeat (dep_wait) tick();
    money_counting = 1;
    tick();
    take_receipt = receipt;
    tick();
    another_transaction_bit = 0;
    tick();
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    Card_in = 1; Pers_Account_No = 17'd1000; password = 17'd1111; Timer = 1'($urandom);
    opcode = 3'($urandom); take_receipt = 1;
    reset = 1;
    begin_trace();
    tick();
    n_checks++;
    if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0); end
    reset = 0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.u_db.r_bal[i] !== 19'(m_bal[i])) begin
        n_fail++; $display("FAIL reset_balance[%0d]: got %0d want %0d", i, dut.u_db.r_bal[i], m_bal[i]);
      end
    end
  endtask

  task automatic test_balance();
    apply_reset();
    run_session(1000, 1111, 1, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (trace[3] !== 7'b0) begin n_fail++; $display("FAIL balance_early: got %b want %b", trace[3], 7'b0); end
    n_checks++;
    if (trace[4] !== P_BAL) begin n_fail++; $display("FAIL balance_pulse: got %b want %b", trace[4], P_BAL); end
    n_checks++;
    if (trace[5] !== P_RCPT) begin n_fail++; $display("FAIL balance_receipt: got %b want %b", trace[5], P_RCPT); end
    n_checks++;
    if (trace[6] !== 7'b0) begin n_fail++; $display("FAIL balance_another: got %b want %b", trace[6], 7'b0); end
    n_checks++;
    if (trace[7] !== P_FIN) begin n_fail++; $display("FAIL balance_finish: got %b want %b", trace[7], P_FIN); end
  endtask

  task automatic test_withdraw();
    int want [3] = '{2000, 6000, 3000};
    logic [6:0] wpulse [3] = '{P_WD, 7'b0, P_WD};
    int wbal [3] = '{3000, 3000, 0};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      run_session(1000, 1111, 2, want[k], 0, 1, 0, 0, 0);
      n_checks++;
      if (trace[4] !== wpulse[k]) begin
        n_fail++; $display("FAIL withdraw_pulse[%0d]: got %b want %b", k, trace[4], wpulse[k]);
      end
      n_checks++;
      if (dut.u_db.r_bal[0] !== 19'(wbal[k])) begin
        n_fail++; $display("FAIL withdraw_balance[%0d]: got %0d want %0d", k, dut.u_db.r_bal[0], wbal[k]);
      end
    end
  endtask

  task automatic test_deposit();
    apply_reset();
    run_session(4000, 4444, 3, 500, 0, 0, 0, 3, 0);
    n_checks++;
    if ((trace[4] | trace[5] | trace[6]) !== 7'b0) begin
      n_fail++; $display("FAIL deposit_wait: got %b want %b", trace[4] | trace[5] | trace[6], 7'b0);
    end
    n_checks++;
    if (trace[7] !== P_DEP) begin n_fail++; $display("FAIL deposit_pulse: got %b want %b", trace[7], P_DEP); end
    run_session(4000, 4444, 3, AMT_LIMIT - 500, 0, 0, 0, 0, 0);
    n_checks++;
    if (trace[4] !== P_DEP) begin n_fail++; $display("FAIL deposit_to_max: got %b want %b", trace[4], P_DEP); end
    n_checks++;
    if (dut.u_db.r_bal[3] !== 19'(AMT_LIMIT)) begin
      n_fail++; $display("FAIL deposit_max_bal: got %0d want %0d", dut.u_db.r_bal[3], AMT_LIMIT);
    end
    run_session(4000, 4444, 3, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (trace[4] !== 7'b0) begin n_fail++; $display("FAIL deposit_overflow: got %b want %b", trace[4], 7'b0); end
    n_checks++;
    if (dut.u_db.r_bal[3] !== 19'(AMT_LIMIT)) begin
      n_fail++; $display("FAIL deposit_overflow_bal: got %0d want %0d", dut.u_db.r_bal[3], AMT_LIMIT);
    end
  endtask

  task automatic test_transfer();
    int dst [4] = '{2000, 1000, 9999, 2000};
    bit ok [4] = '{1, 1, 1, 0};
    logic [6:0] tp [4] = '{P_XFER, 7'b0, 7'b0, 7'b0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_session(1000, 1111, 4, 1000, dst[k], ok[k], 0, 0, 0);
      n_checks++;
      if (trace[4] !== tp[k]) begin n_fail++; $display("FAIL transfer_pulse[%0d]: got %b want %b", k, trace[4], tp[k]); end
      n_checks++;
      if (dut.u_db.r_bal[0] !== 19'd4000 || dut.u_db.r_bal[1] !== 19'd4000) begin
        n_fail++; $display("FAIL transfer_bal[%0d]: got %0d/%0d want 4000/4000", k, dut.u_db.r_bal[0], dut.u_db.r_bal[1]);
      end
    end
  endtask

  task automatic test_wrong_pin();
    apply_reset();
    begin_trace();
    Card_in = 1; Pers_Account_No = 17'd2000; password = 17'd0;
    repeat (6) tick();
    idle_inputs();
    n_checks++;
    if ((trace[0] | trace[1] | trace[2] | trace[3] | trace[4]) !== 7'b0) begin
      n_fail++; $display("FAIL wrong_pin_early: got %b want %b", trace[0] | trace[1] | trace[2] | trace[3] | trace[4], 7'b0);
    end
    n_checks++;
    if (trace[5] !== P_FIN) begin n_fail++; $display("FAIL wrong_pin_exit: got %b want %b", trace[5], P_FIN); end
    tick();
    run_session(2000, 2222, 1, 0, 0, 0, 1, 0, 0);
`ifdef PIN_LOCKOUT_EN
    n_checks++;
    if (sess_or !== 7'b0) begin n_fail++; $display("FAIL reinsert_locked: got %b want %b", sess_or, 7'b0); end
`else
    n_checks++;
    if (sess_or !== (P_BAL | P_RCPT | P_FIN)) begin
      n_fail++; $display("FAIL reinsert_retry: got %b want %b", sess_or, P_BAL | P_RCPT | P_FIN);
    end
`endif
  endtask

  task automatic test_pin_retry();
    apply_reset();
    begin_trace();
    Card_in = 1; Pers_Account_No = 17'd3000; password = 17'd0;
    tick(); tick(); tick(); tick();
    password = 17'd3333; opcode = 3'b001;
    tick(); tick(); tick();
    n_checks++;
    if (obs !== P_BAL) begin n_fail++; $display("FAIL pin_retry_balance: got %b want %b", obs, P_BAL); end
    take_receipt = 0;
    tick(); tick(); tick();
    n_checks++;
    if (sess_or !== (P_BAL | P_FIN)) begin n_fail++; $display("FAIL pin_retry_session: got %b want %b", sess_or, P_BAL | P_FIN); end
    idle_inputs();
  endtask

  task automatic test_another();
    apply_reset();
    begin_trace();
    Card_in = 1; Pers_Account_No = 17'd1000; password = 17'd1111; opcode = 3'b001;
    tick(); tick(); tick(); tick(); tick();
    tick();
    another_transaction_bit = 1; password = 17'd0;
    tick();
    opcode = 3'b010; another_transaction_bit = 0;
    tick();
    allowwithdraw = 1; withdraw_amount = 19'd100;
    tick();
    n_checks++;
    if (obs !== P_WD) begin n_fail++; $display("FAIL another_withdraw: got %b want %b", obs, P_WD); end
    tick(); tick(); tick();
    n_checks++;
    if (obs !== P_FIN) begin n_fail++; $display("FAIL another_finish: got %b want %b", obs, P_FIN); end
    n_checks++;
    if (dut.u_db.r_bal[0] !== 19'd4900) begin n_fail++; $display("FAIL another_balance: got %0d want 4900", dut.u_db.r_bal[0]); end
    idle_inputs();
  endtask

  task automatic test_abort();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      begin_trace();
      Card_in = 1; Pers_Account_No = 17'd1000; password = 17'd1111; opcode = (k == 0) ? 3'b010 : 3'b011;
      tick(); tick(); tick(); tick();
      allowwithdraw = 1; withdraw_amount = 19'd100; deposit_amount = 19'd100; money_counting = 1;
      if (k == 0) Card_in = 0; else Timer = 1;
      tick();
      Card_in = 0; Timer = 0;
      tick();
      n_checks++;
      if (trace[4] !== 7'b0) begin n_fail++; $display("FAIL abort_pulse[%0d]: got %b want %b", k, trace[4], 7'b0); end
      n_checks++;
      if (trace[5] !== P_FIN) begin n_fail++; $display("FAIL abort_finish[%0d]: got %b want %b", k, trace[5], P_FIN); end
      n_checks++;
      if (dut.u_db.r_bal[0] !== 19'd5000) begin n_fail++; $display("FAIL abort_balance[%0d]: got %0d want 5000", k, dut.u_db.r_bal[0]); end
      idle_inputs();
    end
  endtask

  task automatic test_random();
    int a, op, sel, amt, di, dest, npin;
    bit confirm, receipt;
    logic [6:0] exp;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      a = $urandom_range(0, 3); op = $urandom_range(1, 5); sel = $urandom_range(0, 7);
      amt = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(500000, AMT_LIMIT)) : int'($urandom_range(1, 6000));
      di = $urandom_range(0, 4);
      dest = (di == 4) ? 9999 : m_acct[di];
      confirm = ($urandom_range(0, 3) != 0); receipt = 1'($urandom);
      npin = $urandom_range(1, 99999);
      run_session(m_acct[a], m_pin[a], op, amt, dest, confirm, receipt, 0, npin);
      exp = model_session(m_acct[a], op, amt, dest, confirm, receipt, npin);
      n_checks++;
      if (sess_or !== exp) begin n_fail++; $display("FAIL random_session[%0d] op %0d: got %b want %b", s, op, sess_or, exp); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dut.u_db.r_bal[i] !== 19'(m_bal[i])) begin
          n_fail++; $display("FAIL random_balance[%0d][%0d]: got %0d want %0d", s, i, dut.u_db.r_bal[i], m_bal[i]);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_balance();
    test_withdraw();
    test_deposit();
    test_transfer();
    test_wrong_pin();
    test_pin_retry();
    test_another();
    test_abort();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
